m_seq_sync: RTL and testbench
=============================

Name: m_seq_sync

Overview:
- Receive-side counterpart to the 4-stage m-sequence generator (recurrence s[n] = s[n-1] ^ s[n-4], period 15).
- Sits after the BPSK demodulator/bit decision, on the recovered serial bit stream.
- Self-synchronises a local copy of the sequence to the incoming bits, declares lock, then flywheels the local copy and counts bit errors for BER measurement.
- Drops lock on excessive errors.

Parameters:
- LOCK_CNT, 8: consecutive correct predictions in VERIFY needed to enter LOCKED.
- WIN_LEN, 64: length of the error-monitoring window in LOCKED, in valid bits.
- LOSS_THR, 8: error count within one window that causes loss of lock.
- CNT_W, 16: width of the bit and error counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous reset, active low.
- data_in  in  1  received bit; sampled only when data_vld=1.
- data_vld  in  1  qualifies data_in; one bit per high cycle; gaps allowed.
- clr  in  1  synchronous clear of bit_cnt/err_cnt; lock state unaffected.
- locked  out  1  high while in LOCKED.
- err_flag  out  1  one-cycle pulse, one per mismatched bit while LOCKED.
- sync_lost  out  1  one-cycle pulse on the LOCKED->SEARCH transition.
- bit_cnt  out  CNT_W  valid bits checked while LOCKED; saturating.
- err_cnt  out  CNT_W  mismatches while LOCKED; saturating.

Behaviour:
- Reset: one clock, asynchronous active-low reset (clk, rst_n). Asserting rst_n at any time, including mid-lock, forces state=SEARCH, fill=0, hist=0, lfsr=0, and all outputs (locked, err_flag, sync_lost, bit_cnt, err_cnt) to 0.
- hist: 4-bit shift register of received bits, hist[0] newest. It shifts on every data_vld in every state.
- Prediction p = hist[3] ^ hist[0] in SEARCH/VERIFY, and lfsr[3] ^ lfsr[0] in LOCKED.
- All outputs are registered. err_flag and sync_lost assert the cycle after the data_vld cycle carrying the offending bit.
- Cycles with data_vld=0 change nothing except clearing the pulse outputs.
- SEARCH:
  - Count fill 0..4 on each data_vld.
  - When fill reaches 4 and hist != 0, go to VERIFY with match=0.
  - While hist==0, remain in SEARCH. The all-zero state is not a valid m-sequence state.
- VERIFY:
  - On data_vld, compare data_in with p. Match: match+1. Mismatch: match=0 and stay in VERIFY (history self-resyncs).
  - When match reaches LOCK_CNT, go to LOCKED: load lfsr with the history including the current bit, set locked=1, reset win=0 and werr=0.
- LOCKED:
  - On data_vld, lfsr shifts in its own prediction p, never data_in (flywheel: one channel error = exactly one counted error).
  - bit_cnt+1. Mismatch: err_flag=1, err_cnt+1, werr+1.
  - win counts to WIN_LEN-1, then wraps to 0 and clears werr.
  - If werr reaches LOSS_THR (checked including the current bit): go to SEARCH, fill=0, locked=0, sync_lost=1 for one cycle. Counters hold their values.
- Counters:
  - bit_cnt and err_cnt saturate at 2^CNT_W-1 and never wrap.
  - clr has priority over an increment in the same cycle (result is 0).
- Simultaneous events: window wrap and the LOSS_THR-th error in the same bit means loss wins.

Decomposition:
- Package m_seq_pkg holds:
  - SEQ_LEN=15, SEQ_ORDER=4.
  - Tap constant (stages 3 and 0).
  - State enum {SEARCH, VERIFY, LOCKED}.
  - Reset seed 4'b1001, so the generator and checker share one definition.
- One natural sub-module, m_seq_lfsr: 4-bit register with load, load value, advance, and a combinational next-bit output. It is used for the flywheel copy and is reusable by the generator.

Test Plan:
1. Clean lock: drive the generator stream from seed 1001 (1,0,0,1,0,0,0,1,1,1,1,0,1,0,1 repeating), data_vld always high. locked rises the cycle after bit 12 (4 fill + 8 matches). After 100 further bits: bit_cnt=100, err_cnt=0, err_flag never asserted.
2. Single error: in LOCKED, invert one bit. Exactly one err_flag pulse; err_cnt=1; locked stays 1; the next 30 bits produce no err_flag (no propagation).
3. All-zero input: 200 zero bits. locked stays 0 and state stays SEARCH.
4. Loss of lock: after lock, invert 8 bits within one 64-bit window. sync_lost pulses once, the cycle after the 8th error; locked=0; err_cnt=8. Clean stream afterwards relocks after 12 bits.
5. Gapped valid: same stream as 1 with data_vld toggling 1/0. Lock after the 12th valid bit; counters identical to scenario 1.
6. Reset/clear: assert rst_n=0 mid-lock. Outputs go to 0 immediately. Separately, clr pulsed while LOCKED zeroes both counters without dropping locked.

Source files
------------

// File: rtl/m_seq_pkg.sv
// ============================================================================
//  Module      : m_seq_pkg
//  Description : Shared definitions for the 4-stage m-sequence generator and
//                its receive-side synchroniser (s[n] = s[n-1] ^ s[n-4]).
//                Holds the sequence geometry, the feedback taps, the common
//                reset seed and the synchroniser state type.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package m_seq_pkg;

    localparam int SEQ_LEN   = 15;
    localparam int SEQ_ORDER = 4;

    // Feedback taps on stages 3 and 0 (stage 0 holds the newest bit).
    localparam logic [SEQ_ORDER-1:0] SEQ_TAPS = 4'b1001;

    // Generator start state; the checker reconstructs phase from the stream.
    localparam logic [SEQ_ORDER-1:0] SEQ_SEED = 4'b1001;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } seq_state_t;

    // Next sequence bit predicted from a 4-bit history window.
    function automatic logic seq_next_bit(input logic [SEQ_ORDER-1:0] s);
        return ^(s & SEQ_TAPS);
    endfunction

endpackage

`default_nettype wire

// File: rtl/m_seq_lfsr.sv
// ============================================================================
//  Module      : m_seq_lfsr
//  Description : 4-bit Fibonacci LFSR for the m-sequence. Loadable, advances
//                on request, and exposes the next bit combinationally.
//  Ports       : clk         system clock, rising edge
//                rst_n       asynchronous reset, active low
//                i_load      load i_load_val (has priority over i_adv)
//                i_load_val  value to load, bit 0 = newest bit
//                i_adv       shift the predicted next bit into the register
//                o_next_bit  bit the register will shift in on advance
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module m_seq_lfsr
    import m_seq_pkg::*;
#(
    parameter logic [SEQ_ORDER-1:0] RST_VAL = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_load,
    input  logic [SEQ_ORDER-1:0] i_load_val,
    input  logic                 i_adv,
    output logic                 o_next_bit
);

    logic [SEQ_ORDER-1:0] r_state;
    logic                 w_next;

    assign w_next     = seq_next_bit(r_state);
    assign o_next_bit = w_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RST_VAL;
        end else if (i_load) begin
            r_state <= i_load_val;
        end else if (i_adv) begin
            r_state <= {r_state[SEQ_ORDER-2:0], w_next};
        end
    end

endmodule

`default_nettype wire

// File: rtl/m_seq_sync.sv
// ============================================================================
//  Module      : m_seq_sync
//  Description : Self-synchronising m-sequence checker for BER measurement.
//                Fills a 4-bit history, verifies LOCK_CNT consecutive
//                predictions, then flywheels a local LFSR copy and counts
//                bit errors. Drops lock when LOSS_THR errors fall within one
//                WIN_LEN-bit window.
//  Ports       : clk        system clock, rising edge
//                rst_n      asynchronous reset, active low
//                data_in    received bit, sampled when data_vld = 1
//                data_vld   qualifies data_in, one bit per high cycle
//                clr        synchronous clear of bit_cnt / err_cnt
//                locked     high while locked
//                err_flag   one-cycle pulse per mismatched bit while locked
//                sync_lost  one-cycle pulse when lock is dropped
//                bit_cnt    bits checked while locked (saturating)
//                err_cnt    mismatches while locked (saturating)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module m_seq_sync
    import m_seq_pkg::*;
#(
    parameter int LOCK_CNT = 8,
    parameter int WIN_LEN  = 64,
    parameter int LOSS_THR = 8,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             data_in,
    input  logic             data_vld,
    input  logic             clr,
    output logic             locked,
    output logic             err_flag,
    output logic             sync_lost,
    output logic [CNT_W-1:0] bit_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int MW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;
    localparam int WW = (WIN_LEN  > 1) ? $clog2(WIN_LEN)      : 1;
    localparam int EW = $clog2(LOSS_THR + 1);

    localparam logic [MW-1:0] c_match_last = MW'(LOCK_CNT - 1);
    localparam logic [WW-1:0] c_win_last   = WW'(WIN_LEN - 1);
    localparam logic [EW-1:0] c_loss_thr   = EW'(LOSS_THR);
    localparam logic [2:0]    c_fill_full  = 3'(SEQ_ORDER);

    seq_state_t           r_state;
    logic [SEQ_ORDER-1:0] r_hist;
    logic [2:0]           r_fill;
    logic [MW-1:0]        r_match;
    logic [WW-1:0]        r_win;
    logic [EW-1:0]        r_werr;
    logic                 r_locked;
    logic                 r_err_flag;
    logic                 r_sync_lost;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [CNT_W-1:0]     r_err_cnt;

    logic [SEQ_ORDER-1:0] w_hist_nxt;
    logic                 w_lfsr_next;
    logic                 w_pred;
    logic                 w_miss;
    logic                 w_chk;
    logic [EW-1:0]        w_werr_inc;
    logic                 w_loss;
    logic                 w_lock;

    assign w_hist_nxt = {r_hist[SEQ_ORDER-2:0], data_in};

    // Before lock the prediction comes from the received history, so a
    // channel error simply washes out of the window. Once locked the local
    // LFSR is the reference and received bits never feed back into it.
    assign w_pred = (r_state == ST_LOCKED) ? w_lfsr_next : seq_next_bit(r_hist);
    assign w_miss = data_in ^ w_pred;

    assign w_chk      = data_vld && (r_state == ST_LOCKED);
    assign w_werr_inc = r_werr + EW'(w_miss);
    assign w_loss     = w_chk && w_miss && (w_werr_inc == c_loss_thr);
    assign w_lock     = data_vld && (r_state == ST_VERIFY) && !w_miss
                        && (r_match == c_match_last);

    // Flywheel copy: seeded with the verified history (current bit included)
    // on the lock transition, then free-running on each valid bit.
    m_seq_lfsr #(
        .RST_VAL    ('0)
    ) u_lfsr (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_lock),
        .i_load_val (w_hist_nxt),
        .i_adv      (w_chk),
        .o_next_bit (w_lfsr_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_SEARCH;
            r_hist      <= '0;
            r_fill      <= '0;
            r_match     <= '0;
            r_win       <= '0;
            r_werr      <= '0;
            r_locked    <= 1'b0;
            r_err_flag  <= 1'b0;
            r_sync_lost <= 1'b0;
        end else begin
            r_err_flag  <= w_chk && w_miss;
            r_sync_lost <= w_loss;
            if (data_vld) begin
                r_hist <= w_hist_nxt;
                case (r_state)
                    ST_SEARCH: begin
                        if (r_fill != c_fill_full) begin
                            r_fill <= r_fill + 3'd1;
                        end
                        // An all-zero history is the LFSR lock-up state and
                        // never occurs in a real m-sequence, so keep waiting.
                        if ((r_fill >= (c_fill_full - 3'd1)) && (w_hist_nxt != '0)) begin
                            r_state <= ST_VERIFY;
                            r_match <= '0;
                        end
                    end
                    ST_VERIFY: begin
                        if (w_miss) begin
                            r_match <= '0;
                        end else if (w_lock) begin
                            r_state  <= ST_LOCKED;
                            r_locked <= 1'b1;
                            r_win    <= '0;
                            r_werr   <= '0;
                        end else begin
                            r_match <= r_match + MW'(1);
                        end
                    end
                    ST_LOCKED: begin
                        // Loss is evaluated before the window wrap so the
                        // threshold error on the last window bit still counts.
                        if (w_loss) begin
                            r_state  <= ST_SEARCH;
                            r_fill   <= '0;
                            r_locked <= 1'b0;
                            r_win    <= '0;
                            r_werr   <= '0;
                        end else if (r_win == c_win_last) begin
                            r_win  <= '0;
                            r_werr <= '0;
                        end else begin
                            r_win  <= r_win + WW'(1);
                            r_werr <= w_werr_inc;
                        end
                    end
                    default: begin
                        r_state <= ST_SEARCH;
                    end
                endcase
            end
        end
    end

    // Statistics counters: saturate rather than wrap; clr beats an increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
            r_err_cnt <= '0;
        end else if (clr) begin
            r_bit_cnt <= '0;
            r_err_cnt <= '0;
        end else if (w_chk) begin
            if (r_bit_cnt != '1) begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
            if (w_miss && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end
    end

    assign locked    = r_locked;
    assign err_flag  = r_err_flag;
    assign sync_lost = r_sync_lost;
    assign bit_cnt   = r_bit_cnt;
    assign err_cnt   = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_m_seq_sync.sv
// ============================================================================
//  Module      : tb_m_seq_sync
//  Description : Self-checking bench for m_seq_sync. A behavioural model
//                tracks the expected outputs: the reference sequence is a
//                table built from the recurrence, and the locked flywheel is
//                a phase index into that table.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_m_seq_sync;

    localparam int LOCK_CNT = 8;
    localparam int WIN_LEN  = 64;
    localparam int LOSS_THR = 8;
    localparam int CNT_W    = 16;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic             clk      = 1'b0;
    logic             rst_n    = 1'b0;
    logic             data_in  = 1'b0;
    logic             data_vld = 1'b0;
    logic             clr      = 1'b0;
    logic             locked;
    logic             err_flag;
    logic             sync_lost;
    logic [CNT_W-1:0] bit_cnt;
    logic [CNT_W-1:0] err_cnt;

    always #5 clk = ~clk;

    m_seq_sync #(
        .LOCK_CNT  (LOCK_CNT),
        .WIN_LEN   (WIN_LEN),
        .LOSS_THR  (LOSS_THR),
        .CNT_W     (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .data_vld  (data_vld),
        .clr       (clr),
        .locked    (locked),
        .err_flag  (err_flag),
        .sync_lost (sync_lost),
        .bit_cnt   (bit_cnt),
        .err_cnt   (err_cnt)
    );

    wire [2+2*CNT_W:0] w_obs = {locked, err_flag, sync_lost, bit_cnt, err_cnt};

    int n_pass = 0;
    int n_chk  = 0;

    // Reference sequence and generator phase
    bit seq [15];
    int g_ph;

    // Behavioural model state (mode 0 search, 1 verify, 2 locked)
    int m_mode, m_fill, m_match, m_win, m_werr, m_ph, m_bits, m_errs;
    bit m_hq [$];   // last 4 received bits, index 3 newest
    bit m_locked, m_err, m_lost;

    function automatic void build_seq();
        seq[0] = 1'b1; seq[1] = 1'b0; seq[2] = 1'b0; seq[3] = 1'b1;
        for (int n = 4; n < 15; n++) seq[n] = seq[n-1] ^ seq[n-4];
    endfunction

    function automatic bit gen_bit();
        bit b;
        b = seq[g_ph];
        g_ph = (g_ph + 1) % 15;
        return b;
    endfunction

    function automatic void model_reset();
        m_mode = 0; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0;
        m_ph = -1; m_bits = 0; m_errs = 0;
        m_locked = 1'b0; m_err = 1'b0; m_lost = 1'b0;
        m_hq.delete();
        for (int i = 0; i < 4; i++) m_hq.push_back(1'b0);
    endfunction

    // Every non-zero 4-bit window occurs exactly once per period.
    function automatic int find_phase();
        for (int k = 0; k < 15; k++) begin
            if (seq[(k+12)%15] == m_hq[0] && seq[(k+13)%15] == m_hq[1] &&
                seq[(k+14)%15] == m_hq[2] && seq[k] == m_hq[3])
                return k;
        end
        return -1;
    endfunction

    function automatic void push_hist(input bit d);
        m_hq.push_back(d);
        void'(m_hq.pop_front());
    endfunction

    function automatic void model_step(input bit v, input bit d, input bit c);
        bit p, e;
        m_err  = 1'b0;
        m_lost = 1'b0;
        if (v) begin
            p = m_hq[3] ^ m_hq[0];
            case (m_mode)
                0: begin
                    if (m_fill < 4) m_fill++;
                    push_hist(d);
                    if (m_fill == 4 && (m_hq[0] | m_hq[1] | m_hq[2] | m_hq[3])) begin
                        m_mode  = 1;
                        m_match = 0;
                    end
                end
                1: begin
                    push_hist(d);
                    if (d == p) begin
                        m_match++;
                        if (m_match == LOCK_CNT) begin
                            m_mode = 2; m_locked = 1'b1; m_win = 0; m_werr = 0;
                            m_ph = find_phase();
                        end
                    end else begin
                        m_match = 0;
                    end
                end
                default: begin
                    if (m_ph >= 0) begin
                        m_ph = (m_ph + 1) % 15;
                        e = seq[m_ph];
                    end else begin
                        e = 1'b0;
                    end
                    push_hist(d);
                    if (m_bits < CNT_MAX) m_bits++;
                    if (d != e) begin
                        m_err = 1'b1;
                        if (m_errs < CNT_MAX) m_errs++;
                        m_werr++;
                    end
                    if (m_werr == LOSS_THR) begin
                        m_mode = 0; m_fill = 0; m_locked = 1'b0; m_lost = 1'b1;
                        m_win = 0; m_werr = 0;
                    end else if (m_win == WIN_LEN - 1) begin
                        m_win = 0; m_werr = 0;
                    end else begin
                        m_win++;
                    end
                end
            endcase
        end
        if (c) begin
            m_bits = 0;
            m_errs = 0;
        end
    endfunction

    function automatic logic [2+2*CNT_W:0] exp_vec();
        return {m_locked, m_err, m_lost, CNT_W'(m_bits), CNT_W'(m_errs)};
    endfunction

    task automatic drive(input bit v, input bit d, input bit c);
        @(negedge clk);
        data_vld = v;
        data_in  = d;
        clr      = c;
        @(posedge clk);
        model_step(v, d, c);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        data_vld = 1'b0;
        clr      = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        n_chk++;
        if (w_obs !== '0) $display("FAIL reset_state got=%h exp=0", w_obs);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_clean_lock();
        int lock_at = -1;
        int flags   = 0;
        do_reset();
        g_ph = 0;
        for (int i = 1; i <= 112; i++) begin
            drive(1'b1, gen_bit(), 1'b0);
            n_chk++;
            if (w_obs !== exp_vec()) $display("FAIL clean_outputs bit=%0d got=%h exp=%h", i, w_obs, exp_vec());
            else n_pass++;
            if (locked && lock_at < 0) lock_at = i;
            if (err_flag) flags++;
        end
        n_chk++;
        if (lock_at !== 12) $display("FAIL clean_lock_bit got=%0d exp=12", lock_at);
        else n_pass++;
        n_chk++;
        if (bit_cnt !== 16'd100 || err_cnt !== 16'd0 || flags !== 0)
            $display("FAIL clean_counts bits=%0d errs=%0d flags=%0d exp=100/0/0", bit_cnt, err_cnt, flags);
        else n_pass++;
    endtask

    task automatic test_single_error();
        int k      = $urandom_range(0, 9);
        int pulses = 0;
        bit b;
        for (int i = 0; i < 41; i++) begin
            b = gen_bit();
            if (i == k) b = ~b;
            drive(1'b1, b, 1'b0);
            n_chk++;
            if (w_obs !== exp_vec()) $display("FAIL single_outputs i=%0d got=%h exp=%h", i, w_obs, exp_vec());
            else n_pass++;
            if (err_flag) pulses++;
        end
        n_chk++;
        if (pulses !== 1 || err_cnt !== 16'd1 || locked !== 1'b1)
            $display("FAIL single_error pulses=%0d errs=%0d locked=%0b exp=1/1/1", pulses, err_cnt, locked);
        else n_pass++;
    endtask

    task automatic test_all_zero();
        int seen = 0;
        do_reset();
        for (int i = 0; i < 200; i++) begin
            drive(1'b1, 1'b0, 1'b0);
            n_chk++;
            if (w_obs !== exp_vec()) $display("FAIL zero_outputs i=%0d got=%h exp=%h", i, w_obs, exp_vec());
            else n_pass++;
            if (locked) seen++;
        end
        n_chk++;
        if (seen !== 0 || bit_cnt !== 16'd0) $display("FAIL zero_nolock lockcycles=%0d bits=%0d exp=0/0", seen, bit_cnt);
        else n_pass++;
    endtask

    task automatic test_loss();
        bit mask [20];
        int nmask = 0, nerr = 0, nlost = 0, lock_at = -1, j;
        bit b;
        do_reset();
        g_ph = $urandom_range(0, 14);
        for (int i = 1; i <= 12; i++) drive(1'b1, gen_bit(), 1'b0);
        n_chk++;
        if (locked !== 1'b1) $display("FAIL loss_prelock got=%0b exp=1", locked);
        else n_pass++;
        while (nmask < 8) begin
            j = $urandom_range(0, 19);
            if (!mask[j]) begin mask[j] = 1'b1; nmask++; end
        end
        for (int i = 0; i < 20 && nerr < 8; i++) begin
            b = gen_bit();
            if (mask[i]) begin b = ~b; nerr++; end
            drive(1'b1, b, 1'b0);
            n_chk++;
            if (w_obs !== exp_vec()) $display("FAIL loss_outputs i=%0d got=%h exp=%h", i, w_obs, exp_vec());
            else n_pass++;
            if (sync_lost) nlost++;
        end
        n_chk++;
        if (sync_lost !== 1'b1 || locked !== 1'b0 || err_cnt !== 16'd8 || nlost !== 1)
            $display("FAIL loss_event lost=%0b locked=%0b errs=%0d pulses=%0d exp=1/0/8/1", sync_lost, locked, err_cnt, nlost);
        else n_pass++;
        for (int i = 1; i <= 12; i++) begin
            drive(1'b1, gen_bit(), 1'b0);
            n_chk++;
            if (w_obs !== exp_vec()) $display("FAIL relock_outputs i=%0d got=%h exp=%h", i, w_obs, exp_vec());
            else n_pass++;
            if (sync_lost) nlost++;
            if (locked && lock_at < 0) lock_at = i;
        end
        n_chk++;
        if (lock_at !== 12 || nlost !== 1) $display("FAIL relock_bit got=%0d pulses=%0d exp=12/1", lock_at, nlost);
        else n_pass++;
    endtask

    task automatic test_gapped();
        int lock_at = -1;
        do_reset();
        g_ph = 0;
        for (int i = 1; i <= 112; i++) begin
            drive(1'b1, gen_bit(), 1'b0);
            n_chk++;
            if (w_obs !== exp_vec()) $display("FAIL gap_outputs bit=%0d got=%h exp=%h", i, w_obs, exp_vec());
            else n_pass++;
            if (locked && lock_at < 0) lock_at = i;
            drive(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            n_chk++;
            if (w_obs !== exp_vec()) $display("FAIL gap_idle bit=%0d got=%h exp=%h", i, w_obs, exp_vec());
            else n_pass++;
        end
        n_chk++;
        if (lock_at !== 12 || bit_cnt !== 16'd100 || err_cnt !== 16'd0)
            $display("FAIL gap_summary lock=%0d bits=%0d errs=%0d exp=12/100/0", lock_at, bit_cnt, err_cnt);
        else n_pass++;
    endtask

    task automatic test_clear_reset();
        bit b;
        do_reset();
        g_ph = $urandom_range(0, 14);
        for (int i = 0; i < 30; i++) drive(1'b1, gen_bit(), 1'b0);
        drive(1'b1, gen_bit(), 1'b1);   // clear coincides with an increment
        n_chk++;
        if (w_obs !== exp_vec() || bit_cnt !== 16'd0 || locked !== 1'b1)
            $display("FAIL clr_with_inc got=%h exp=%h", w_obs, exp_vec());
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            b = gen_bit();
            if (i == 2) b = ~b;
            drive(1'b1, b, 1'b0);
        end
        n_chk++;
        if (bit_cnt !== 16'd6 || err_cnt !== 16'd1) $display("FAIL clr_precount bits=%0d errs=%0d exp=6/1", bit_cnt, err_cnt);
        else n_pass++;
        drive(1'b0, 1'b0, 1'b1);
        n_chk++;
        if (w_obs !== exp_vec() || err_cnt !== 16'd0 || locked !== 1'b1)
            $display("FAIL clr_idle got=%h exp=%h", w_obs, exp_vec());
        else n_pass++;
        for (int i = 0; i < 5; i++) drive(1'b1, gen_bit(), 1'b0);
        #2;
        rst_n = 1'b0;              // asynchronous, between clock edges
        model_reset();
        #1;
        n_chk++;
        if (w_obs !== '0) $display("FAIL async_reset got=%h exp=0", w_obs);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        int rate = 0;
        bit v, c, d;
        do_reset();
        g_ph = $urandom_range(0, 14);
        for (int i = 0; i < 3000; i++) begin
            if (i % 256 == 0) rate = $urandom_range(0, 15);
            if ($urandom_range(0, 199) == 0) g_ph = $urandom_range(0, 14);
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 99) == 0);
            if (v) d = gen_bit() ^ ($urandom_range(0, 99) < rate);
            else   d = 1'($urandom_range(0, 1));
            drive(v, d, c);
            n_chk++;
            if (w_obs !== exp_vec()) $display("FAIL random_outputs cyc=%0d got=%h exp=%h", i, w_obs, exp_vec());
            else n_pass++;
        end
    endtask

    initial begin
        build_seq();
        model_reset();
        test_reset();
        test_clean_lock();
        test_single_error();
        test_all_zero();
        test_loss();
        test_gapped();
        test_clear_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule

`default_nettype wire
